// File: rtl/cpu_pkg.sv
// Shared types and constants for the cpu core: opcodes, FSM states,
// instruction field positions and offset sign-extension helpers.
package cpu_pkg;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 15;

  localparam int OP_MSB  = 15;
  localparam int OP_LSB  = 12;
  localparam int RD_MSB  = 11;
  localparam int RD_LSB  = 8;
  localparam int RS1_MSB = 7;
  localparam int RS1_LSB = 4;
  localparam int RS2_MSB = 3;
  localparam int RS2_LSB = 0;

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0,
    OP_ADD  = 4'h1,
    OP_SUB  = 4'h2,
    OP_AND  = 4'h3,
    OP_OR   = 4'h4,
    OP_XOR  = 4'h5,
    OP_LW   = 4'h6,
    OP_SW   = 4'h7,
    OP_LI   = 4'h8,
    OP_LUI  = 4'h9,
    OP_ADDI = 4'hA,
    OP_BEQZ = 4'hB,
    OP_JMP  = 4'hC,
    OP_JR   = 4'hD,
    OP_SC   = 4'hE,
    OP_HALT = 4'hF
  } opcode_e;

  typedef enum logic [1:0] {
    ST_FETCH   = 2'd0,
    ST_EXECUTE = 2'd1,
    ST_HALTED  = 2'd2
  } state_e;

  function automatic logic [ADDR_W-1:0] sext8_pc(input logic [7:0] v);
    return {{(ADDR_W-8){v[7]}}, v};
  endfunction

  function automatic logic [ADDR_W-1:0] sext12_pc(input logic [11:0] v);
    return {{(ADDR_W-12){v[11]}}, v};
  endfunction

endpackage

// File: rtl/cpu_regfile.sv
// 16 x 16 general-purpose register file: two asynchronous read ports,
// one synchronous write port, r0 always reads zero.
module cpu_regfile
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        i_raddr_a,
  input  logic [3:0]        i_raddr_b,
  output logic [DATA_W-1:0] o_rdata_a,
  output logic [DATA_W-1:0] o_rdata_b,
  input  logic              i_we,
  input  logic [3:0]        i_waddr,
  input  logic [DATA_W-1:0] i_wdata
);

  logic [DATA_W-1:0] registers [16];

  // NOTE: the GPRs must read zero after reset, so the array is reset
  // explicitly; this keeps it out of plain RAM macros, which cannot reset.
  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) registers[i] <= '0;
    end else if (i_we && (i_waddr != 4'd0)) begin
      registers[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata_a = (i_raddr_a == 4'd0) ? '0 : registers[i_raddr_a];
  assign o_rdata_b = (i_raddr_b == 4'd0) ? '0 : registers[i_raddr_b];

endmodule

// File: rtl/cpu.sv
// Two-cycle (FETCH/EXECUTE) 16-bit core on a single word-addressed memory port.
// Optional system-control registers and opcode 0xE enabled by CPU_SC_REGS_EN.
module cpu
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata
);

  logic [3:0]        w_ra;
  logic [3:0]        w_rb;
  logic [DATA_W-1:0] w_rs_a;
  logic [DATA_W-1:0] w_rs_b;
  logic              w_rf_we;
  logic [3:0]        w_rf_waddr;
  logic [DATA_W-1:0] w_rf_wdata;

  cpu_regfile register_file (
    .clk       (clk),
    .rst       (rst),
    .i_raddr_a (w_ra),
    .i_raddr_b (w_rb),
    .o_rdata_a (w_rs_a),
    .o_rdata_b (w_rs_b),
    .i_we      (w_rf_we),
    .i_waddr   (w_rf_waddr),
    .i_wdata   (w_rf_wdata)
  );

  if (1) begin : ctrl
    state_e            r_state;
    state_e            w_next_state;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] w_pc_next;
    logic [ADDR_W-1:0] w_pc_inc;
    logic [ADDR_W-1:0] w_ls_addr;
    logic [DATA_W-1:0] r_ir;
    opcode_e           w_op;
    logic [3:0]        w_rd;

    assign w_op      = opcode_e'(r_ir[OP_MSB:OP_LSB]);
    assign w_rd      = r_ir[RD_MSB:RD_LSB];
    assign w_pc_inc  = pc + 15'd1;
    assign w_ls_addr = w_rs_a[DATA_W-1:1] + {11'd0, r_ir[RS2_MSB:RS2_LSB]};

    // Port B serves rs2 for ALU ops and rd for everything else (SW, ADDI, BEQZ, JR, SC).
    assign w_ra       = r_ir[RS1_MSB:RS1_LSB];
    assign w_rb       = (w_op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR})
                        ? r_ir[RS2_MSB:RS2_LSB] : w_rd;
    assign w_rf_waddr = w_rd;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= ST_FETCH;
      else     r_state <= w_next_state;
    end

    always_comb begin
      w_next_state = r_state;
      case (r_state)
        ST_FETCH:   w_next_state = ST_EXECUTE;
        ST_EXECUTE: w_next_state = (w_op == OP_HALT) ? ST_HALTED : ST_FETCH;
        default:    w_next_state = ST_HALTED;
      endcase
    end

`ifdef CPU_SC_REGS_EN
    logic [DATA_W-1:0] sc_regs [4];
    logic              w_sc_we;
`endif

    // NOTE: every output gets a default first so no path leaves a latch.
    always_comb begin
      mem_addr   = pc;
      mem_we     = 1'b0;
      mem_wdata  = '0;
      w_rf_we    = 1'b0;
      w_rf_wdata = '0;
      w_pc_next  = w_pc_inc;
`ifdef CPU_SC_REGS_EN
      w_sc_we    = 1'b0;
`endif
      if (r_state == ST_EXECUTE) begin
        case (w_op)
          OP_ADD:  begin w_rf_we = 1'b1; w_rf_wdata = w_rs_a + w_rs_b; end
          OP_SUB:  begin w_rf_we = 1'b1; w_rf_wdata = w_rs_a - w_rs_b; end
          OP_AND:  begin w_rf_we = 1'b1; w_rf_wdata = w_rs_a & w_rs_b; end
          OP_OR:   begin w_rf_we = 1'b1; w_rf_wdata = w_rs_a | w_rs_b; end
          OP_XOR:  begin w_rf_we = 1'b1; w_rf_wdata = w_rs_a ^ w_rs_b; end
          OP_LW:   begin mem_addr = w_ls_addr; w_rf_we = 1'b1; w_rf_wdata = mem_rdata; end
          OP_SW:   begin mem_addr = w_ls_addr; mem_we = 1'b1; mem_wdata = w_rs_b; end
          OP_LI:   begin w_rf_we = 1'b1; w_rf_wdata = {8'h00, r_ir[7:0]}; end
          OP_LUI:  begin w_rf_we = 1'b1; w_rf_wdata = {r_ir[7:0], w_rs_b[7:0]}; end
          OP_ADDI: begin
            w_rf_we    = 1'b1;
            w_rf_wdata = w_rs_b + {{8{r_ir[7]}}, r_ir[7:0]};
          end
          OP_BEQZ: if (w_rs_b == '0) w_pc_next = w_pc_inc + sext8_pc(r_ir[7:0]);
          OP_JMP:  w_pc_next = w_pc_inc + sext12_pc(r_ir[11:0]);
          OP_JR:   w_pc_next = w_rs_b[DATA_W-1:1];
`ifdef CPU_SC_REGS_EN
          OP_SC: begin
            if (r_ir[7]) begin
              w_sc_we = 1'b1;
            end else begin
              w_rf_we    = 1'b1;
              w_rf_wdata = sc_regs[r_ir[1:0]];
            end
          end
`endif
          OP_HALT: w_pc_next = pc;
          default: ;
        endcase
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        pc   <= '0;
        r_ir <= '0;
      end else if (r_state == ST_FETCH) begin
        r_ir <= mem_rdata;
      end else if (r_state == ST_EXECUTE) begin
        pc <= w_pc_next;
      end
    end

`ifdef CPU_SC_REGS_EN
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int i = 0; i < 4; i++) sc_regs[i] <= '0;
      end else if (w_sc_we) begin
        sc_regs[r_ir[1:0]] <= w_rs_b;
      end
    end
`endif
  end

endmodule

// File: tb/tb_cpu.sv
// Self-checking bench for cpu: 128x16 memory, instruction-level reference
// model compared against the DUT on every cycle, plus literal spot checks.
module tb_cpu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] mem_rdata;
  logic        mem_we;
  logic [14:0] mem_addr;
  logic [15:0] mem_wdata;

  logic [15:0] mem      [128];
  logic [15:0] load_img [128];
  logic        load_req = 1'b0;
  int          we_count = 0;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state (architectural, one instruction at a time)
  logic [14:0] m_pc;
  logic [15:0] m_regs [16];
  logic [15:0] m_sc   [4];
  logic [15:0] m_mem  [128];
  bit          m_halted;

  cpu dut (
    .clk       (clk),
    .rst       (rst),
    .mem_rdata (mem_rdata),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata)
  );

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr[6:0]];

  always @(posedge clk) begin
    if (load_req)    mem <= load_img;
    else if (mem_we) mem[mem_addr[6:0]] <= mem_wdata;
  end

  always @(posedge clk) if (mem_we) we_count <= we_count + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] rreg(input logic [3:0] i);
    return (i == 4'd0) ? 16'h0000 : m_regs[i];
  endfunction

  task automatic wreg(input logic [3:0] i, input logic [15:0] v);
    if (i != 4'd0) m_regs[i] = v;
  endtask

  task automatic m_reset();
    m_pc     = '0;
    m_halted = 1'b0;
    for (int i = 0; i < 16; i++) m_regs[i] = '0;
    for (int i = 0; i < 4; i++)  m_sc[i]   = '0;
  endtask

  task automatic put(input int addr, input logic [15:0] w);
    load_img[addr] = w;
    m_mem[addr]    = w;
  endtask

  // Assert reset, check reset outputs, clear both memory images.
  task automatic start_test(input string tag);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check({tag, " rst pc"},    dut.ctrl.pc, 15'd0);
    check({tag, " rst we"},    mem_we,      1'b0);
    check({tag, " rst addr"},  mem_addr,    15'd0);
    check({tag, " rst wdata"}, mem_wdata,   16'd0);
    for (int i = 0; i < 128; i++) put(i, 16'h0000);
  endtask

  task automatic release_reset();
    load_req = 1'b1;
    @(posedge clk);
    #1 load_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    m_reset();
  endtask

  // One instruction = two cycles; called just after a negedge in FETCH.
  task automatic step(input string tag);
    logic [15:0] inst, a, b, d, ld;
    logic [3:0]  op, rd, rs1, rs2;
    logic [14:0] ea, pc1, nxt;
    if (m_halted) begin
      #1 check({tag, " halted we"}, mem_we, 1'b0);
      @(negedge clk);
      #1 check({tag, " halted we"}, mem_we, 1'b0);
      check({tag, " halted pc"}, dut.ctrl.pc, m_pc);
      @(negedge clk);
      return;
    end
    #1;
    check({tag, " fetch addr"}, mem_addr, m_pc);
    check({tag, " fetch we"},   mem_we,   1'b0);
    inst = m_mem[m_pc[6:0]];
    op = inst[15:12]; rd = inst[11:8]; rs1 = inst[7:4]; rs2 = inst[3:0];
    a = rreg(rs1); b = rreg(rs2); d = rreg(rd);
    ea  = a[15:1] + {11'd0, rs2};
    pc1 = m_pc + 15'd1;
    nxt = pc1;
    @(negedge clk);
    #1;
    if (op == 4'h7) begin
      check({tag, " sw addr"},  mem_addr,  ea);
      check({tag, " sw we"},    mem_we,    1'b1);
      check({tag, " sw wdata"}, mem_wdata, d);
    end else begin
      if (op == 4'h6) check({tag, " lw addr"}, mem_addr, ea);
      check({tag, " exec we"}, mem_we, 1'b0);
    end
    case (op)
      4'h1: wreg(rd, a + b);
      4'h2: wreg(rd, a - b);
      4'h3: wreg(rd, a & b);
      4'h4: wreg(rd, a | b);
      4'h5: wreg(rd, a ^ b);
      4'h6: begin ld = m_mem[ea[6:0]]; wreg(rd, ld); end
      4'h7: m_mem[ea[6:0]] = d;
      4'h8: wreg(rd, {8'h00, inst[7:0]});
      4'h9: wreg(rd, {inst[7:0], d[7:0]});
      4'hA: wreg(rd, d + {{8{inst[7]}}, inst[7:0]});
      4'hB: if (d == 16'h0000) nxt = pc1 + {{7{inst[7]}}, inst[7:0]};
      4'hC: nxt = pc1 + {{3{inst[11]}}, inst[11:0]};
      4'hD: nxt = d[15:1];
`ifdef CPU_SC_REGS_EN
      4'hE: if (inst[7]) m_sc[inst[1:0]] = d; else wreg(rd, m_sc[inst[1:0]]);
`endif
      4'hF: begin m_halted = 1'b1; nxt = m_pc; end
      default: ;
    endcase
    m_pc = nxt;
    @(negedge clk);
    #1;
    check({tag, " pc"}, dut.ctrl.pc, m_pc);
    for (int i = 0; i < 16; i++)
      check($sformatf("%s r%0d", tag, i), dut.register_file.registers[i], rreg(i[3:0]));
  endtask

  initial begin
    int we_before;

    // Boot: LI r1,0xFF at word 2 after two NOPs
    start_test("boot");
    put(2, 16'h81FF);
    release_reset();
    repeat (3) step("boot");
    check("boot r1 literal", dut.register_file.registers[1], 16'd255);
    check("boot byte pc", {dut.ctrl.pc, 1'b0}, 16'd6);
    repeat (3) step("boot nop");
    check("boot r1 stays", dut.register_file.registers[1], 16'd255);

    // ALU, LUI, ADDI and r0 write protection
    start_test("alu");
    put(0, 16'h8205); put(1, 16'h8307); put(2, 16'h1423); put(3, 16'h2523);
    put(4, 16'h3623); put(5, 16'h4723); put(6, 16'h5823); put(7, 16'h8934);
    put(8, 16'h9912); put(9, 16'hA9FF); put(10, 16'h8005);
    release_reset();
    repeat (11) step("alu");
    check("alu add r4",  dut.register_file.registers[4], 16'd12);
    check("alu sub r5",  dut.register_file.registers[5], 16'hFFFE);
    check("alu and r6",  dut.register_file.registers[6], 16'd5);
    check("alu or r7",   dut.register_file.registers[7], 16'd7);
    check("alu xor r8",  dut.register_file.registers[8], 16'd2);
    check("alu addi r9", dut.register_file.registers[9], 16'h1233);
    check("alu r0 zero", dut.register_file.registers[0], 16'd0);

    // Store/load pair, then a store that rewrites its own word before refetch
    start_test("mem");
    put(0, 16'h8140); put(1, 16'h82AB); put(2, 16'h7211); put(3, 16'h6311);
    put(4, 16'h8577); put(5, 16'h9587); put(6, 16'h7506); put(7, 16'hCFFE);
    put(16'h21, 16'h5A5A);
    release_reset();
    we_before = we_count;
    repeat (4) step("mem");
    check("mem we cycles", we_count - we_before, 1);
    check("mem word 0x21", mem[7'h21], 16'h00AB);
    check("mem lw r3", dut.register_file.registers[3], 16'h00AB);
    repeat (5) step("mem self");
    check("mem self word", mem[6], 16'h8777);
    check("mem self r7", dut.register_file.registers[7], 16'h0077);

    // Taken BEQZ, JR, then JMP -1 spinning at word 5
    start_test("br");
    put(0, 16'hB002); put(1, 16'h8101); put(2, 16'h8101);
    put(3, 16'h830A); put(4, 16'hD300); put(5, 16'hCFFF);
    release_reset();
    repeat (7) step("br");
    check("br loop pc", dut.ctrl.pc, 15'd5);
    check("br skipped r1", dut.register_file.registers[1], 16'd0);

    // Not-taken BEQZ, then HALT freezes everything
    start_test("halt");
    put(0, 16'h8107); put(1, 16'hB103); put(2, 16'hF000); put(3, 16'h8109);
    release_reset();
    repeat (6) step("halt");
    check("halt pc literal", dut.ctrl.pc, 15'd2);
    check("halt r1 literal", dut.register_file.registers[1], 16'd7);

    // System-control write then read back
    start_test("sc");
    put(0, 16'h81FF); put(1, 16'hE180); put(2, 16'hE200);
    release_reset();
    repeat (3) step("sc");
`ifdef CPU_SC_REGS_EN
    check("sc r2 literal", dut.register_file.registers[2], 16'd255);
    check("sc reg0", dut.ctrl.sc_regs[0], 16'd255);
`else
    check("sc r2 nop", dut.register_file.registers[2], 16'd0);
`endif

    // pc wraps from 0x7FFF to 0
    start_test("wrap");
    put(0, 16'hCFFE);
    release_reset();
    step("wrap");
    check("wrap pc max", dut.ctrl.pc, 15'h7FFF);
    step("wrap");
    check("wrap pc zero", dut.ctrl.pc, 15'd0);

    // Reset during SW execute drops the store
    start_test("rstsw");
    put(0, 16'h8140); put(1, 16'h82AB); put(2, 16'h7211);
    put(16'h21, 16'h5A5A);
    release_reset();
    repeat (2) step("rstsw");
    #1 check("rstsw fetch addr", mem_addr, 15'd2);
    @(negedge clk);
    #1 check("rstsw we before", mem_we, 1'b1);
    rst = 1'b1;
    #1;
    check("rstsw we drop", mem_we, 1'b0);
    check("rstsw wdata drop", mem_wdata, 16'd0);
    @(posedge clk);
    #1;
    check("rstsw word kept", mem[7'h21], 16'h5A5A);
    check("rstsw pc", dut.ctrl.pc, 15'd0);
    check("rstsw r2 cleared", dut.register_file.registers[2], 16'd0);
    @(negedge clk);
    rst = 1'b0;
    m_reset();
    step("rstsw restart");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
